// File: rtl/hazard_stall_ctrl_if.sv
// Interface bundling the hazard controller's pipeline-facing signals.
// The slave modport is the controller's view; the master modport is the
// pipeline's view (it supplies hazard inputs and consumes enables/flushes).
// The three perf counters are only meaningful when the controller is built
// with HAZ_PERF_EN; otherwise they read as zero.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  // ID / EX hazard inputs
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic             ID_uses_rs2;
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_RD;
  // Redirect and memory-readiness inputs
  logic             branch_taken;
  logic             ICACHE_stall;
  logic             DCACHE_stall;
  // Pipeline register controls
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Write;
  logic             EXMEM_Write;
  logic             MEMWB_Write;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             stall_active;
  // Performance counters
  logic [CNT_W-1:0] lu_bubble_cnt;
  logic [CNT_W-1:0] mem_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_RS1, ID_RS2, ID_uses_rs2, IDEX_MemRead, IDEX_RD,
    output branch_taken, ICACHE_stall, DCACHE_stall,
    input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
    input  IFID_Flush, IDEX_Flush, stall_active,
    input  lu_bubble_cnt, mem_stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_uses_rs2, IDEX_MemRead, IDEX_RD,
    input  branch_taken, ICACHE_stall, DCACHE_stall,
    output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
    output IFID_Flush, IDEX_Flush, stall_active,
    output lu_bubble_cnt, mem_stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the 5-stage RV32 core.
// Handles what the EX forwarding unit cannot: load-use bubbles (LU_BUBBLES
// per hazard), a global freeze while either cache stalls, and IF/ID + ID/EX
// flushes on a taken redirect from EX. A redirect that arrives while frozen
// is remembered and applied on the first unfrozen cycle.
// All outputs are Mealy (registered state + current inputs).
// Optional build macro: HAZ_PERF_EN adds three wrapping perf counters
// (load-use bubble cycles, cache freeze cycles, branch flush cycles);
// without it the counter outputs are tied to zero.
module hazard_stall_ctrl #(
  parameter int LU_BUBBLES = 1,   // legal 1..7
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Bubbles still owed after the one inserted on the detection cycle.
  localparam logic [2:0] LU_RELOAD = 3'(LU_BUBBLES - 1);
  localparam bit         LU_MULTI  = (LU_BUBBLES > 1);

  state_t     state_reg, state_next;
  logic [2:0] bub_cnt_reg, bub_cnt_next;
  logic       br_pend_reg, br_pend_next;

  logic       mem_stall;
  logic       lu_haz;
  logic       br;
  logic       bub_owed;
  logic [2:0] bub_dec;

  // One-hot indication of which priority rule governs this cycle.
  logic       rule_mem;
  logic       rule_br;
  logic       rule_bub;
  logic       rule_lu;

  // Local copies of the outputs so the interface is driven in one place.
  logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_flush, stall_act;

  assign mem_stall = hz.ICACHE_stall | hz.DCACHE_stall;
  assign br        = hz.branch_taken | br_pend_reg;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_haz = hz.IDEX_MemRead && (hz.IDEX_RD != 5'd0) &&
                  ((hz.IDEX_RD == hz.ID_RS1) ||
                   (hz.ID_uses_rs2 && (hz.IDEX_RD == hz.ID_RS2)));

  // Bubbles remain outstanding either mid-sequence or when a freeze
  // interrupted a sequence that still had bubbles left.
  assign bub_owed = (state_reg == LU_STALL) ||
                    ((state_reg == MEM_WAIT) && (bub_cnt_reg != 3'd0));

  // Saturate at zero so an impossible LU_STALL with bub_cnt=0 cannot wrap.
  assign bub_dec = (bub_cnt_reg == 3'd0) ? 3'd0 : bub_cnt_reg - 3'd1;

  // Rule selection in strict priority order: freeze, redirect, owed bubble, new hazard.
  always_comb begin
    rule_mem = 1'b0;
    rule_br  = 1'b0;
    rule_bub = 1'b0;
    rule_lu  = 1'b0;
    if (!rst) begin
      if (mem_stall)     rule_mem = 1'b1;
      else if (br)       rule_br  = 1'b1;
      else if (bub_owed) rule_bub = 1'b1;
      else if (lu_haz)   rule_lu  = 1'b1;
    end
  end

  // State register; reset abandons any stall and forgets a pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      bub_cnt_reg <= 3'd0;
      br_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bub_cnt_reg <= bub_cnt_next;
      br_pend_reg <= br_pend_next;
    end
  end

  // Next-state and Mealy outputs for the selected rule.
  always_comb begin
    state_next   = RUN;
    bub_cnt_next = bub_cnt_reg;
    br_pend_next = br_pend_reg;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    memwb_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    stall_act    = 1'b0;

    if (rst) begin
      // Pipeline registers load NOPs while reset is held.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (rule_mem) begin
      // Whole pipeline freezes; a redirect seen now is replayed on release.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      stall_act   = 1'b1;
      state_next  = MEM_WAIT;
      if (hz.branch_taken) begin
        br_pend_next = 1'b1;
      end
    end else if (rule_br) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed, which
      // includes any load-use victim, so outstanding bubbles are dropped.
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      br_pend_next = 1'b0;
      bub_cnt_next = 3'd0;
      state_next   = RUN;
    end else if (rule_bub) begin
      // Hold PC and IF/ID, inject a NOP into EX.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_flush   = 1'b1;
      stall_act    = 1'b1;
      bub_cnt_next = bub_dec;
      state_next   = (bub_dec != 3'd0) ? LU_STALL : RUN;
    end else if (rule_lu) begin
      // First bubble goes in on the detection cycle itself.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_flush   = 1'b1;
      stall_act    = 1'b1;
      bub_cnt_next = LU_RELOAD;
      state_next   = LU_MULTI ? LU_STALL : RUN;
    end else begin
      state_next = RUN;
    end
  end

  assign hz.PC_Write     = pc_write;
  assign hz.IFID_Write   = ifid_write;
  assign hz.IDEX_Write   = idex_write;
  assign hz.EXMEM_Write  = exmem_write;
  assign hz.MEMWB_Write  = memwb_write;
  assign hz.IFID_Flush   = ifid_flush;
  assign hz.IDEX_Flush   = idex_flush;
  assign hz.stall_active = stall_act;

`ifdef HAZ_PERF_EN
  // Counter index: 0 = load-use bubble cycles, 1 = freeze cycles, 2 = flushes.
  logic [2:0]       perf_inc;
  logic [CNT_W-1:0] perf_cnt [3];

  assign perf_inc = {rule_br, rule_mem, (rule_bub | rule_lu)};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;

      // Free-running event counter, wraps naturally at 2^CNT_W.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (perf_inc[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign perf_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign hz.lu_bubble_cnt = perf_cnt[0];
  assign hz.mem_stall_cnt = perf_cnt[1];
  assign hz.flush_cnt     = perf_cnt[2];
`else
  assign hz.lu_bubble_cnt = '0;
  assign hz.mem_stall_cnt = '0;
  assign hz.flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LU_BUBBLES=1 and 3) share one
// directed stimulus stream. A per-cycle model tracks "bubbles still owed" and
// "redirect pending" and derives every output; literal checks pin key cycles.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       use2 = 1'b0, mr = 1'b0, bt = 1'b0, ic = 1'b0, dc = 1'b0;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus1 ();
  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus3 ();

  assign bus1.ID_RS1 = rs1;  assign bus3.ID_RS1 = rs1;
  assign bus1.ID_RS2 = rs2;  assign bus3.ID_RS2 = rs2;
  assign bus1.ID_uses_rs2 = use2;  assign bus3.ID_uses_rs2 = use2;
  assign bus1.IDEX_MemRead = mr;   assign bus3.IDEX_MemRead = mr;
  assign bus1.IDEX_RD = rd;  assign bus3.IDEX_RD = rd;
  assign bus1.branch_taken = bt;   assign bus3.branch_taken = bt;
  assign bus1.ICACHE_stall = ic;   assign bus3.ICACHE_stall = ic;
  assign bus1.DCACHE_stall = dc;   assign bus3.DCACHE_stall = dc;

  hazard_stall_ctrl #(.LU_BUBBLES(1), .CNT_W(CNT_W)) u1 (.clk(clk), .rst(rst), .hz(bus1));
  hazard_stall_ctrl #(.LU_BUBBLES(3), .CNT_W(CNT_W)) u3 (.clk(clk), .rst(rst), .hz(bus3));

  // Output vector order: {PC, IFID, IDEX, EXMEM, MEMWB, IFID_Flush, IDEX_Flush, stall}
  logic [7:0]       outs [2];
  logic [CNT_W-1:0] c_lu [2], c_mem [2], c_fl [2];

  assign outs[0] = {bus1.PC_Write, bus1.IFID_Write, bus1.IDEX_Write, bus1.EXMEM_Write,
                    bus1.MEMWB_Write, bus1.IFID_Flush, bus1.IDEX_Flush, bus1.stall_active};
  assign outs[1] = {bus3.PC_Write, bus3.IFID_Write, bus3.IDEX_Write, bus3.EXMEM_Write,
                    bus3.MEMWB_Write, bus3.IFID_Flush, bus3.IDEX_Flush, bus3.stall_active};
  assign c_lu[0]  = bus1.lu_bubble_cnt;  assign c_lu[1]  = bus3.lu_bubble_cnt;
  assign c_mem[0] = bus1.mem_stall_cnt;  assign c_mem[1] = bus3.mem_stall_cnt;
  assign c_fl[0]  = bus1.flush_cnt;      assign c_fl[1]  = bus3.flush_cnt;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, step_no, got, exp);
    end
  endtask

  // Model state: bubbles still owed, a remembered redirect, and event tallies.
  int          nb      [2] = '{1, 3};
  int          owed    [2] = '{0, 0};
  bit          pend    [2] = '{0, 0};
  int unsigned m_lu    [2] = '{0, 0};
  int unsigned m_mem   [2] = '{0, 0};
  int unsigned m_fl    [2] = '{0, 0};

  localparam logic [7:0] O_RESET  = 8'b11111_11_0;
  localparam logic [7:0] O_FREEZE = 8'b00000_00_1;
  localparam logic [7:0] O_FLUSH  = 8'b11111_11_0;
  localparam logic [7:0] O_BUBBLE = 8'b00111_01_1;
  localparam logic [7:0] O_NORMAL = 8'b11111_00_0;

  // Compare every cycle on the falling edge, then advance the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] e;
      bit ms, haz;
      ms  = ic || dc;
      haz = mr && (rd != 0) && ((rd == rs1) || (use2 && (rd == rs2)));
`ifdef HAZ_PERF_EN
      chk(k == 0 ? "lu_cnt_b1" : "lu_cnt_b3", c_lu[k], m_lu[k]);
      chk(k == 0 ? "mem_cnt_b1" : "mem_cnt_b3", c_mem[k], m_mem[k]);
      chk(k == 0 ? "fl_cnt_b1" : "fl_cnt_b3", c_fl[k], m_fl[k]);
`else
      chk(k == 0 ? "lu_cnt_b1" : "lu_cnt_b3", c_lu[k], 0);
      chk(k == 0 ? "mem_cnt_b1" : "mem_cnt_b3", c_mem[k], 0);
      chk(k == 0 ? "fl_cnt_b1" : "fl_cnt_b3", c_fl[k], 0);
`endif
      if (rst) begin
        e = O_RESET;
        owed[k] = 0; pend[k] = 0; m_lu[k] = 0; m_mem[k] = 0; m_fl[k] = 0;
      end else if (ms) begin
        e = O_FREEZE;
        if (bt) pend[k] = 1;
        m_mem[k]++;
      end else if (bt || pend[k]) begin
        e = O_FLUSH;
        pend[k] = 0; owed[k] = 0;
        m_fl[k]++;
      end else if (owed[k] > 0) begin
        e = O_BUBBLE;
        owed[k]--;
        m_lu[k]++;
      end else if (haz) begin
        e = O_BUBBLE;
        owed[k] = nb[k] - 1;
        m_lu[k]++;
      end else begin
        e = O_NORMAL;
      end
      chk(k == 0 ? "outs_b1" : "outs_b3", outs[k], e);
    end
  end

  // One cycle of stimulus; returns at the falling edge of that cycle.
  task automatic apply(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic u2, input logic m, input logic [4:0] d,
                       input logic b, input logic i, input logic dd);
    @(posedge clk); #1;
    rst = r; rs1 = a1; rs2 = a2; use2 = u2; mr = m; rd = d; bt = b; ic = i; dc = dd;
    step_no++;
    @(negedge clk);
    $display("step %0d rst=%0b rs1=%0d rs2=%0d u2=%0b mr=%0b rd=%0d bt=%0b ic=%0b dc=%0b | b1=%b b3=%b",
             step_no, r, a1, a2, u2, m, d, b, i, dd, outs[0], outs[1]);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 5, 0, 0, 1, 5, 0, 0, 0);
    chk("rst_pcw", bus1.PC_Write, 1);
    chk("rst_flush", {bus1.IFID_Flush, bus1.IDEX_Flush}, 2'b11);
    chk("rst_stall", bus3.stall_active, 0);
    idle(1);
    chk("run_normal", outs[0], 8'b11111_00_0);

    // lw x5 ; use x5 via rs1
    apply(0, 5, 0, 0, 1, 5, 0, 0, 0);
    chk("lu1_bubble", {bus1.PC_Write, bus1.IFID_Write, bus1.IDEX_Flush}, 3'b001);
    chk("lu3_bubble_a", bus3.stall_active, 1);
    apply(0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("lu1_released", bus1.PC_Write, 1);
    chk("lu3_bubble_b", bus3.PC_Write, 0);
    apply(0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("lu3_bubble_c", bus3.IDEX_Flush, 1);
    apply(0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("lu3_released", bus3.stall_active, 0);

    // No-stall cases: x0 target, rs2 match without use, then rs2 match with use
    apply(0, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("x0_no_stall", bus3.stall_active, 0);
    apply(0, 3, 7, 0, 1, 7, 0, 0, 0);
    chk("rs2_unused", bus1.stall_active, 0);
    apply(0, 3, 7, 1, 1, 7, 0, 0, 0);
    chk("rs2_used", bus1.stall_active, 1);
    idle(3);

    // D-cache freeze during 2nd bubble of the 3-bubble instance
    apply(0, 5, 0, 0, 1, 5, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      apply(0, 5, 0, 0, 0, 0, 0, 0, 1);
      chk("freeze_writes", bus3.PC_Write | bus3.IFID_Write | bus3.IDEX_Write |
                           bus3.EXMEM_Write | bus3.MEMWB_Write, 0);
    end
    apply(0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("post_freeze_bub1", bus3.stall_active, 1);
`ifdef HAZ_PERF_EN
    chk("mem_cnt_4", bus3.mem_stall_cnt, 4);
`endif
    apply(0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("post_freeze_bub2", bus3.stall_active, 1);
    apply(0, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("post_freeze_done", bus3.stall_active, 0);

    // Branch pulse during an I-cache freeze
    apply(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("br_frz_noflush", bus1.IFID_Flush, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("br_frz_noflush3", bus3.IDEX_Flush, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_release_flush", {bus1.IFID_Flush, bus1.IDEX_Flush}, 2'b11);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_flush_once", bus1.IFID_Flush, 0);
`ifdef HAZ_PERF_EN
    chk("flush_cnt_1", bus1.flush_cnt, 1);
`endif

    // Branch and load-use in the same cycle: branch wins
    apply(0, 5, 0, 0, 1, 5, 1, 0, 0);
    chk("br_lu_pcw", bus1.PC_Write, 1);
    chk("br_lu_flush", {bus3.IFID_Flush, bus3.IDEX_Flush, bus3.stall_active}, 3'b110);
    idle(1);

    // Branch during a 3-bubble sequence squashes remaining bubbles
    apply(0, 6, 0, 0, 1, 6, 0, 0, 0);
    apply(0, 6, 0, 0, 0, 0, 1, 0, 0);
    chk("br_in_lu", bus3.IFID_Flush, 1);
    idle(1);
    chk("br_in_lu_done", bus3.stall_active, 0);

    // Reset in LU_STALL with two bubbles owed
    apply(0, 9, 0, 0, 1, 9, 0, 0, 0);
    apply(1, 9, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_flush", bus3.IFID_Flush, 1);
    apply(0, 9, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_nobub", bus3.stall_active, 0);
    chk("rst_mid_cnt", bus3.lu_bubble_cnt, 0);
    apply(0, 9, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_nobub2", bus3.PC_Write, 1);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core; partner to the EX-stage forwarding unit. Covers hazards forwarding cannot resolve:
- load-use bubbles (configurable count)
- global freeze on I/D cache stall
- IF/ID and ID/EX flush on taken branch/jump resolved in EX, including a branch that arrives during a freeze.

It drives pipeline-register write enables and flush controls.

Parameters:
LU_BUBBLES, 1, bubbles inserted per load-use hazard; legal 1..7
CNT_W, 32, width of perf counters (used only with HAZ_PERF_EN)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
ID_RS1  input  5  rs1 of instruction in ID
ID_RS2  input  5  rs2 of instruction in ID
ID_uses_rs2  input  1  ID instruction reads rs2 (R/S/B types)
IDEX_MemRead  input  1  instruction in EX is a load
IDEX_RD  input  5  rd of instruction in EX
branch_taken  input  1  EX redirect (taken branch/jal/jalr); may be a 1-cycle pulse
ICACHE_stall  input  1  instruction memory not ready
DCACHE_stall  input  1  data memory not ready
PC_Write  output  1  PC load enable
IFID_Write  output  1  IF/ID register enable
IDEX_Write  output  1  ID/EX register enable
EXMEM_Write  output  1  EX/MEM register enable
MEMWB_Write  output  1  MEM/WB register enable
IFID_Flush  output  1  zero IF/ID on next edge
IDEX_Flush  output  1  load NOP into ID/EX on next edge
stall_active  output  1  any stall/freeze this cycle
lu_bubble_cnt  output  CNT_W  load-use bubble count
mem_stall_cnt  output  CNT_W  cache freeze cycle count
flush_cnt  output  CNT_W  branch flush count

Behaviour:
- Registered state only: state {RUN, LU_STALL, MEM_WAIT}, bub_cnt[2:0], br_pend. All outputs are combinational from state plus inputs (Mealy).
- Reset:
  - state=RUN, bub_cnt=0, br_pend=0, counters=0.
  - While rst=1: all *_Write=1, IFID_Flush=IDEX_Flush=1, stall_active=0.
- Definitions:
  - mem_stall = ICACHE_stall | DCACHE_stall.
  - lu_haz = IDEX_MemRead & (IDEX_RD!=0) & ((IDEX_RD==ID_RS1) | (ID_uses_rs2 & (IDEX_RD==ID_RS2))).
  - br = branch_taken | br_pend.
- Priority each cycle, from any state:
  1. mem_stall=1:
     - All five *_Write=0, flushes=0, stall_active=1.
     - If branch_taken, set br_pend=1.
     - bub_cnt held; next state MEM_WAIT.
  2. Else if br=1:
     - All writes=1, IFID_Flush=1, IDEX_Flush=1, stall_active=0.
     - br_pend cleared; bub_cnt cleared (the load-use victim is squashed).
     - Next state RUN.
  3. Else if state==LU_STALL, or (state==MEM_WAIT and bub_cnt!=0):
     - PC_Write=0, IFID_Write=0, IDEX_Flush=1, other writes=1, stall_active=1.
     - bub_cnt decrements; next state LU_STALL if the decremented value is !=0, else RUN.
  4. Else if lu_haz:
     - Same outputs as rule 3.
     - bub_cnt = LU_BUBBLES-1; next state LU_STALL if LU_BUBBLES>1, else RUN.
  5. Else: all writes=1, flushes=0, stall_active=0; next state RUN.
- Latency: the hazard is detected and the bubble inserted in the same cycle (zero-latency), so the LU_BUBBLES=1 default gives exactly one bubble.
- MEM_WAIT exit: in the first cycle with mem_stall=0, rules 2–5 apply directly. No dead cycle.
- Simultaneous events:
  - branch + lu_haz: branch wins, no bubble.
  - branch + mem_stall: freeze first, then flush on the release cycle.
  - lu_haz during MEM_WAIT with bub_cnt=0: evaluated normally on release.
- x0 never causes a stall.
- Reset mid-stall: abandons the stall and flushes; there is no residual bub_cnt or br_pend.

Optional Feature:
- Macro: HAZ_PERF_EN.
- With HAZ_PERF_EN:
  - lu_bubble_cnt increments on each cycle rule 3 or 4 fires.
  - mem_stall_cnt increments on each rule-1 cycle.
  - flush_cnt increments on each rule-2 cycle.
  - All counters wrap at 2^CNT_W and are cleared by rst.
- Without HAZ_PERF_EN: counter registers are not built and all three outputs are tied to 0.

Test Plan:
- lw x5 in EX (IDEX_MemRead=1, IDEX_RD=5), ID_RS1=5, LU_BUBBLES=1 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1; next cycle all writes 1, state RUN.
- Same hazard with LU_BUBBLES=3 -> three consecutive bubble cycles; with IDEX_RD=0 or ID_uses_rs2=0 and only an RS2 match -> no stall.
- DCACHE_stall high 4 cycles during the 2nd bubble of LU_BUBBLES=3 -> 4 freeze cycles with all writes 0 and mem_stall_cnt=4, then exactly 2 more bubble cycles.
- branch_taken 1-cycle pulse while ICACHE_stall high 3 cycles -> no flush during freeze; IFID_Flush=IDEX_Flush=1 on release cycle only; flush_cnt=1.
- branch_taken and lu_haz in the same cycle -> flushes asserted, PC_Write=1, no bubble, lu_bubble_cnt unchanged.
- rst asserted while in LU_STALL with bub_cnt=2 -> after reset, state RUN, no further bubbles, all counters 0.
